// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// Holds state encoding, default iteration count and result field layout.
package div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ZERO = 2'd1,
    ON       = 2'd2,
    END      = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH      = 32;
  localparam int DIV_CYCLES_DEF = DIV_WIDTH;

  localparam int RES_LO_LSB = 0;
  localparam int RES_LO_MSB = DIV_WIDTH - 1;
  localparam int RES_HI_LSB = DIV_WIDTH;
  localparam int RES_HI_MSB = 2 * DIV_WIDTH - 1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide step.
// Shifts in a dividend bit and subtracts the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvs_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  // rem < divisor always holds, so diff's top bit is a clean borrow flag
  always_comb begin
    sh    = {rem_i, bit_i};
    diff  = sh - {1'b0, dvs_i};
    q_o   = ~diff[WIDTH];
    rem_o = q_o ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit feeding the HI/LO register.
// One quotient bit per clock, with annul and stall support.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_req
);

  localparam int CntW  = $clog2(DIV_CYCLES + 1);
  localparam int HiLsb = (WIDTH == DIV_WIDTH) ? RES_HI_LSB
                                              : RES_LO_LSB + WIDTH;

  div_state_e state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic               sdiv_q, sdiv_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_nx;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvs_i (dvs_q),
    .bit_i (dvd_q[WIDTH-1]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  assign quo_nx    = {quo_q[WIDTH-2:0], step_q};
  assign result    = result_q;
  assign ready     = ready_q;
  assign stall_req = start & ~ready_q;

  // Next-state, datapath and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    sdiv_d   = sdiv_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    ready_d  = 1'b0;
    result_d = '0;

    unique case (state_q)
      IDLE: begin
        if (start && !annul) begin
          cnt_d  = '0;
          rem_d  = '0;
          quo_d  = '0;
          sdiv_d = signed_div;
          s1_d   = opdata1[WIDTH-1];
          s2_d   = opdata2[WIDTH-1];
          if (opdata2 == '0) begin
            state_d = DIV_ZERO;
            dvd_d   = opdata1;
            dvs_d   = '0;
          end else begin
            state_d = ON;
            dvd_d   = (signed_div && opdata1[WIDTH-1])
                      ? -opdata1 : opdata1;
            dvs_d   = (signed_div && opdata2[WIDTH-1])
                      ? -opdata2 : opdata2;
          end
        end
      end
      DIV_ZERO: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          state_d = END;
          quo_d   = '1;
          rem_d   = dvd_q;
        end
      end
      ON: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          dvd_d = dvd_q << 1;
          rem_d = step_rem;
          quo_d = quo_nx;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
            state_d = END;
            if (sdiv_q && (s1_q ^ s2_q)) quo_d = -quo_nx;
            if (sdiv_q && s1_q)          rem_d = -step_rem;
          end
        end
      end
      END: begin
        if (annul || (ready_q && !start)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_q == END) && (state_d == END);
    if (ready_d) begin
      result_d[HiLsb +: WIDTH]      = rem_q;
      result_d[RES_LO_LSB +: WIDTH] = quo_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      sdiv_q   <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      sdiv_q   <= sdiv_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit.
// Each scenario task drives vectors and checks hand-computed results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(32), .DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .stall_req  (stall_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sd, input logic [31:0] a,
                       input logic [31:0] b);
    signed_div = sd;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
  endtask

  // counts edges after E0 until ready, bounded by max
  task automatic wait_ready(input int max, output int n);
    n = 0;
    while (!ready && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic release_start();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; annul = 1'b0;
    signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    #3;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got=%b exp=0", ready);
    end
    checks++;
    if (result !== 64'h0) begin
      errors++; $display("FAIL reset_result got=%h exp=0", result);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL reset_stall got=%b exp=0", stall_req);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_divu();
    int n;
    issue(1'b0, 32'd100, 32'd7);
    tick();
    checks++;
    if (stall_req !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL divu_stall got=%b/%b exp=1/0", stall_req, ready);
    end
    wait_ready(40, n);
    checks++;
    if (n != 33) begin
      errors++; $display("FAIL divu_latency got=%0d exp=33", n);
    end
    checks++;
    if (result !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL divu_result got=%h exp=000000020000000e", result);
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++; $display("FAIL divu_stall_done got=%b exp=0", stall_req);
    end
    tick();
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL divu_hold got=%b exp=1", ready);
    end
    start = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      errors++;
      $display("FAIL divu_drop got=%b/%h exp=0/0", ready, result);
    end
  endtask

  task automatic test_signed();
    int n;
    issue(1'b1, 32'hFFFFFFF9, 32'h00000002);
    tick();
    wait_ready(40, n);
    checks++;
    if (n != 33 || result !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++;
      $display("FAIL div_m7_2 got=%0d/%h exp=33/fffffffffffffffd",
               n, result);
    end
    release_start();
    issue(1'b1, 32'h00000007, 32'hFFFFFFFE);
    tick();
    wait_ready(40, n);
    checks++;
    if (n != 33 || result !== 64'h00000001_FFFFFFFD) begin
      errors++;
      $display("FAIL div_7_m2 got=%0d/%h exp=33/00000001fffffffd",
               n, result);
    end
    release_start();
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF);
    tick();
    wait_ready(40, n);
    checks++;
    if (n != 33 || result !== 64'h00000000_80000000) begin
      errors++;
      $display("FAIL div_ovf got=%0d/%h exp=33/0000000080000000",
               n, result);
    end
    release_start();
  endtask

  task automatic test_div_zero();
    int n;
    issue(1'b0, 32'd5, 32'd0);
    tick();
    wait_ready(40, n);
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL dz_latency got=%0d exp=2", n);
    end
    checks++;
    if (result !== 64'h00000005_FFFFFFFF) begin
      errors++;
      $display("FAIL dz_result got=%h exp=00000005ffffffff", result);
    end
    release_start();
  endtask

  task automatic test_annul();
    int n;
    int seen;
    issue(1'b0, 32'd1000, 32'd3);
    tick();
    repeat (10) tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    annul = 1'b0;
    seen  = 0;
    repeat (30) begin
      if (ready !== 1'b0 || result !== 64'h0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL annul_quiet got=%0d exp=0", seen);
    end
    issue(1'b0, 32'd9, 32'd3);
    tick();
    wait_ready(40, n);
    checks++;
    if (n != 33 || result !== 64'h00000000_00000003) begin
      errors++;
      $display("FAIL annul_next got=%0d/%h exp=33/0000000000000003",
               n, result);
    end
    release_start();
  endtask

  task automatic test_reset_mid();
    int n;
    issue(1'b0, 32'd50, 32'd1);
    tick();
    wait_ready(40, n);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      errors++;
      $display("FAIL rst_async got=%b/%h exp=0/0", ready, result);
    end
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    issue(1'b0, 32'd1000, 32'd7);
    tick();
    repeat (19) tick();
    #2 rst = 1'b0;
    start = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'h0) begin
      errors++;
      $display("FAIL rst_mid got=%b/%h exp=0/0", ready, result);
    end
    tick();
    rst = 1'b1;
    tick();
    issue(1'b0, 32'hFFFFFFFF, 32'd1);
    tick();
    wait_ready(40, n);
    checks++;
    if (n != 33 || result !== 64'h00000000_FFFFFFFF) begin
      errors++;
      $display("FAIL rst_next got=%0d/%h exp=33/00000000ffffffff",
               n, result);
    end
    release_start();
  endtask

  task automatic test_operand_change();
    int n;
    issue(1'b0, 32'd100, 32'd7);
    tick();
    repeat (5) tick();
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    signed_div = 1'b1;
    start      = 1'b0;
    wait_ready(40, n);
    checks++;
    if (n != 28 || result !== 64'h00000002_0000000E) begin
      errors++;
      $display("FAIL opchg got=%0d/%h exp=28/000000020000000e",
               n, result);
    end
    tick();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL opchg_drop got=%b exp=0", ready);
    end
  endtask

  task automatic test_start_annul();
    int seen;
    issue(1'b0, 32'd8, 32'd0);
    annul = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      errors++; $display("FAIL sa_stall got=%b exp=1", stall_req);
    end
    seen = 0;
    repeat (4) begin
      tick();
      if (ready !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL sa_noaccept got=%0d exp=0", seen);
    end
    start = 1'b0;
    annul = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_operand_change();
    test_start_annul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per clock.
- Sits in the EX stage directly upstream of the HI/LO register and produces its 64-bit write value {HI=remainder, LO=quotient}.
- Raises a stall request so the pipeline holds the divide instruction in EX until the result is ready.
- Supports cancellation when the instruction is flushed by an exception.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH bits.
- DIV_CYCLES, WIDTH, number of iteration cycles in state ON.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  divide request; the EX stage holds it high until ready is seen
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled only on acceptance
- annul  input  1  cancel the operation in flight (exception or flush)
- opdata1  input  WIDTH  dividend; sampled only on acceptance
- opdata2  input  WIDTH  divisor; sampled only on acceptance
- result  output  2*WIDTH  {remainder, quotient}; intended as the HI/LO write data
- ready  output  1  result valid; also serves as the HI/LO write enable
- stall_req  output  1  combinational: start & ~ready

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; result=0; ready=0; counter=0; internal operands cleared.
  - Takes effect immediately, including mid-operation.
- States: IDLE, DIV_ZERO, ON, END.
- IDLE:
  - start=1 and annul=0 with opdata2==0: go to DIV_ZERO.
  - start=1 and annul=0 with opdata2!=0: go to ON. Latch signed_div and both operand signs. Latch |opdata1| and |opdata2| when signed_div=1, raw values otherwise. Clear counter.
- ON:
  - One restoring step per edge: shift the partial remainder left, bring in the next dividend bit, subtract the divisor if no borrow, and shift in the quotient bit.
  - The counter increments each edge. After DIV_CYCLES steps, go to END.
  - In the same edge, apply sign correction when signed_div=1:
    - negate the quotient when the operand signs differ;
    - negate the remainder when the dividend is negative.
- DIV_ZERO: one cycle, then END with quotient = all ones and remainder = dividend.
- END:
  - ready=1 and result is held stable.
  - When start=0, go to IDLE on the next edge, clearing ready and result.
- annul=1 in ON or DIV_ZERO: go to IDLE on the next edge. Nothing is produced and ready stays 0.
- annul=1 in END: go to IDLE on the next edge.
- annul and start both high in IDLE: annul wins and the request is not accepted.
- start dropping to 0 during ON is ignored; the operation completes, reaches END, then returns to IDLE.
- Latency (start sampled at edge E0):
  - nonzero divisor: ready high after edge E(DIV_CYCLES+1), i.e. E33 for 32 bits;
  - zero divisor: ready high after E2.
- ready is a registered output. result is 0 whenever ready=0.
- Signed overflow: -2^31 / -1 gives quotient 0x80000000, remainder 0. This falls out of unsigned magnitudes plus wrap-around negation; no special case is needed.
- Operands are captured on acceptance, so input changes after E0 have no effect.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, DIV_ZERO, ON, END);
  - DIV_CYCLES default;
  - result field offsets (HI at [63:32], LO at [31:0]).
- One combinational sub-module, div_step: given partial remainder, divisor and incoming bit, it returns the next partial remainder and the quotient bit.
- The FSM, counter and sign correction stay in div_unit.

Test Plan:
- DIVU 100/7, start held: stall_req=1 until ready at E33; result = {0x00000002, 0x0000000E}; ready drops one edge after start falls.
- DIV -7/2 (0xFFFFFFF9, 0x00000002): result = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/-2 gives {0x00000001, 0xFFFFFFFD}.
- DIVU 5/0: ready after E2; result = {0x00000005, 0xFFFFFFFF}. DIV 0x80000000/0xFFFFFFFF gives {0x00000000, 0x80000000} at E33.
- Annul at E10 of DIVU 1000/3: IDLE after E11, ready never asserts, result stays 0. A fresh 9/3 accepted at the next edge yields {0, 3} 33 edges later.
- rst pulsed low mid-operation at cycle 20, between edges: state, result and ready go to 0 immediately without a clock edge. After release, a new DIVU 0xFFFFFFFF/1 gives {0, 0xFFFFFFFF}.
- Operand change after E0 (opdata1 changed to 0 at E5): result unaffected; start and annul both high in IDLE means no acceptance and stall_req=1.
